// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes, debounces and auto-repeats raw push-buttons.
// Each accepted press or repeat gives a 1-cycle strobe. The strobe is also stretched
// into an event long enough for the slow game-core sampler to see it exactly once.

// Per-button debounce / auto-repeat FSM with pulse stretcher.
module button_lane #(
  parameter int DEBOUNCE_CYC = 8,
  parameter int RPT_DLY_CYC  = 40,
  parameter int RPT_PER_CYC  = 16,
  parameter int PULSE_CYC    = 10,
  parameter bit RPT_EN       = 1'b0,
  parameter int CW           = 6
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic s,          // synchronized, polarity-corrected level (1 = pressed)
  output logic level,
  output logic strobe,
  output logic evt
);

  typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_REL} state_t;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DLY_CYC - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PER_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic            from_rpt_q, from_rpt_d;
  logic            lvl_q, lvl_d;
  logic            stb_q, stb_d;

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      from_rpt_q <= 1'b0;
      lvl_q      <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      from_rpt_q <= from_rpt_d;
      lvl_q      <= lvl_d;
      stb_q      <= stb_d;
    end
  end

  // Next-state logic; any bounce restarts the relevant window from zero.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    from_rpt_d = from_rpt_q;
    lvl_d      = lvl_q;
    stb_d      = 1'b0;
    case (st_q)
      IDLE: begin
        if (s) begin
          st_d  = DB_PRESS;
          cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d  = HELD;
          lvl_d = 1'b1;
          stb_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          st_d       = DB_REL;
          from_rpt_d = 1'b0;
          cnt_d      = '0;
        end else if (RPT_EN && cnt_q == DLY_LAST) begin
          st_d  = REPEAT;
          stb_d = 1'b1;
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          st_d       = DB_REL;
          from_rpt_d = 1'b1;
          cnt_d      = '0;
        end else if (cnt_q == PER_LAST) begin
          stb_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_REL: begin
        // A short release glitch drops back to where we came from without a strobe.
        if (s) begin
          st_d  = from_rpt_q ? REPEAT : HELD;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d  = IDLE;
          lvl_d = 1'b0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Stretcher: a strobe (re)loads the down-counter in the same cycle it is issued.
  always_comb begin
    pcnt_d = pcnt_q;
    if (stb_d)              pcnt_d = PULSE_LD;
    else if (pcnt_q != '0)  pcnt_d = pcnt_q - 1'b1;
  end

  assign level  = lvl_q;
  assign strobe = stb_q;
  assign evt    = (pcnt_q != '0);

endmodule

// Top: shared 2-flop synchronizer, then one independent lane per button.
module button_conditioner #(
  parameter int               N_BTN        = 5,
  parameter bit               ACTIVE_LOW   = 1'b0,
  parameter int               DEBOUNCE_CYC = 250000,
  parameter int               RPT_DLY_CYC  = 20000000,
  parameter int               RPT_PER_CYC  = 5000000,
  parameter int               PULSE_CYC    = 1100000,
  parameter logic [N_BTN-1:0] RPT_MASK     = 5'b01011
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_strobe,
  output logic [N_BTN-1:0] btn_evt
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > RPT_DLY_CYC) ? DEBOUNCE_CYC : RPT_DLY_CYC;
  localparam int MAX_CD  = (RPT_PER_CYC > PULSE_CYC) ? RPT_PER_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC);

  // Raw level that means "released"; sync flops reset to it so reset looks like no press.
  localparam logic [N_BTN-1:0] REL = {N_BTN{ACTIVE_LOW}};

  if (PULSE_CYC >= RPT_PER_CYC || DEBOUNCE_CYC < 2) begin : g_bad_param
    $error("button_conditioner: need PULSE_CYC < RPT_PER_CYC and DEBOUNCE_CYC >= 2");
  end

  logic [1:0][N_BTN-1:0] sync_pipe;
  logic [N_BTN-1:0]      s;

  // Two-stage synchronizer for the asynchronous pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_pipe <= {2{REL}};
    else        sync_pipe <= {sync_pipe[0], btn_raw};
  end

  assign s = sync_pipe[1] ^ REL;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_lane #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RPT_DLY_CYC  (RPT_DLY_CYC),
      .RPT_PER_CYC  (RPT_PER_CYC),
      .PULSE_CYC    (PULSE_CYC),
      .RPT_EN       (RPT_MASK[i]),
      .CW           (CW)
    ) u_lane (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .s      (s[i]),
      .level  (btn_level[i]),
      .strobe (btn_strobe[i]),
      .evt    (btn_evt[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a strobe scoreboard (expected cycle/mask queued when
// stimulus is driven), a level/evt vector table for the clean press, and hand sequences
// for bounce, repeat, simultaneous press and reset mid-repeat. A second instance with
// inverted pins runs the clean press in parallel.
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] btn_raw, raw_al;
  logic [4:0] lvl, stb, evt;
  logic [4:0] al_lvl, al_stb, al_evt;

  always #5 CLK = ~CLK;

  button_conditioner #(
    .N_BTN(5), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYC(8), .RPT_DLY_CYC(40),
    .RPT_PER_CYC(16), .PULSE_CYC(10), .RPT_MASK(5'b01011)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_strobe(stb), .btn_evt(evt)
  );

  button_conditioner #(
    .N_BTN(5), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(8), .RPT_DLY_CYC(40),
    .RPT_PER_CYC(16), .PULSE_CYC(10), .RPT_MASK(5'b01011)
  ) u_dut_al (
    .CLK(CLK), .RST_N(RST_N), .btn_raw(raw_al),
    .btn_level(al_lvl), .btn_strobe(al_stb), .btn_evt(al_evt)
  );

  typedef struct { int cyc; logic [4:0] m; } exp_t;
  typedef struct { int off; logic [4:0] raw; logic [4:0] lvl; logic [4:0] evt; } vec_t;

  exp_t exp_q[$];
  vec_t s1[8];
  int   cyc, n_vec, n_fail;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [4:0] m);
    exp_t e;
    e.cyc = c;
    e.m   = m;
    exp_q.push_back(e);
  endtask

  // Pop overdue expectations as misses; match any strobe against the queue head.
  task automatic sb_check();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL strobe_missed cyc=%0d got=none want=%b", e.cyc, e.m);
    end
    if (stb !== 5'b0) begin
      n_vec++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL strobe_extra cyc=%0d got=%b want=none", cyc, stb);
      end else begin
        e = exp_q.pop_front();
        if (stb !== e.m) begin
          n_fail++;
          $display("FAIL strobe_mask cyc=%0d got=%b want=%b", cyc, stb, e.m);
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
      sb_check();
    end
  endtask

  task automatic wait_until(input int t);
    if (t > cyc) wait_cyc(t - cyc);
  endtask

  task automatic drive(input int b, input logic v, input int n);
    btn_raw[b] = v;
    wait_cyc(n);
  endtask

  initial begin
    int e0, e2;
    // Clean press of bit2: raw applied after the check at each offset (sampled at off+1).
    s1[0] = '{-1, 5'b00100, 5'b00000, 5'b00000};
    s1[1] = '{ 9, 5'b00100, 5'b00000, 5'b00000};
    s1[2] = '{10, 5'b00100, 5'b00100, 5'b00100};
    s1[3] = '{19, 5'b00100, 5'b00100, 5'b00100};
    s1[4] = '{20, 5'b00100, 5'b00100, 5'b00000};
    s1[5] = '{29, 5'b00000, 5'b00100, 5'b00000};
    s1[6] = '{39, 5'b00000, 5'b00100, 5'b00000};
    s1[7] = '{40, 5'b00000, 5'b00000, 5'b00000};

    cyc = 0; n_vec = 0; n_fail = 0;
    RST_N = 1'b0; btn_raw = 5'b0; raw_al = 5'b11111;
    wait_cyc(3);
    chk("rst_level", lvl, 5'b0);     chk("rst_strobe", stb, 5'b0);     chk("rst_evt", evt, 5'b0);
    chk("rst_al_level", al_lvl, 5'b0); chk("rst_al_strobe", al_stb, 5'b0); chk("rst_al_evt", al_evt, 5'b0);
    RST_N = 1'b1;
    wait_cyc(20);
    chk("al_idle_level", al_lvl, 5'b0);
    chk("al_idle_evt", al_evt, 5'b0);

    // Clean press on both instances (inverted pins on the active-low one).
    e0 = cyc + 2;
    push(e0 + 10, 5'b00100);
    foreach (s1[i]) begin
      wait_until(e0 + s1[i].off);
      chk("s1_level", lvl, s1[i].lvl);
      chk("s1_evt", evt, s1[i].evt);
      chk("s1_al_level", al_lvl, s1[i].lvl);
      chk("s1_al_evt", al_evt, s1[i].evt);
      btn_raw = s1[i].raw;
      raw_al  = ~s1[i].raw;
    end
    wait_cyc(5);

    // Bounce then a steady phase too short to be accepted.
    drive(0, 1'b1, 1); drive(0, 1'b0, 1); drive(0, 1'b1, 2); drive(0, 1'b0, 1);
    drive(0, 1'b1, 7); drive(0, 1'b0, 20);
    chk("s2_short_level", lvl, 5'b0);

    // Same bounce then a long steady phase: one strobe 10 cycles after the last rise.
    drive(0, 1'b1, 1); drive(0, 1'b0, 1); drive(0, 1'b1, 2); drive(0, 1'b0, 1);
    push(cyc + 1 + 10, 5'b00001);
    drive(0, 1'b1, 20);
    chk("s2_level", lvl, 5'b00001);
    drive(0, 1'b0, 20);
    chk("s2_rel_level", lvl, 5'b0);

    // Long hold with auto-repeat on bit0.
    e0 = cyc + 1;
    btn_raw[0] = 1'b1;
    push(e0 + 10, 5'b00001); push(e0 + 50, 5'b00001); push(e0 + 66, 5'b00001);
    push(e0 + 82, 5'b00001); push(e0 + 98, 5'b00001); push(e0 + 114, 5'b00001);
    wait_until(e0 + 49); chk("s3_level", lvl, 5'b00001); chk("s3_evt_gap0", evt, 5'b0);
    wait_until(e0 + 59); chk("s3_evt_hi", evt, 5'b00001);
    wait_until(e0 + 60); chk("s3_evt_gap1", evt, 5'b0);
    wait_until(e0 + 66); chk("s3_evt_rpt", evt, 5'b00001);
    wait_until(e0 + 119);
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    chk("s3_rel_level", lvl, 5'b0);

    // Simultaneous press of bits 1 and 3 plus a short release glitch.
    e0 = cyc + 1;
    btn_raw = 5'b01010;
    push(e0 + 10, 5'b01010);
    wait_until(e0 + 19);
    btn_raw = 5'b0;
    wait_cyc(3);
    btn_raw = 5'b01010;
    wait_until(e0 + 30);
    chk("s4_glitch_level", lvl, 5'b01010);
    chk("s4_glitch_evt", evt, 5'b0);
    wait_until(e0 + 39);
    btn_raw = 5'b0;
    wait_cyc(25);
    chk("s4_rel_level", lvl, 5'b0);

    // Reset while bit3 repeats; still held afterwards -> fresh press and repeat.
    e0 = cyc + 1;
    btn_raw[3] = 1'b1;
    push(e0 + 10, 5'b01000); push(e0 + 50, 5'b01000);
    wait_until(e0 + 55);
    chk("s5_pre_evt", evt, 5'b01000);
    RST_N = 1'b0;
    #1;
    chk("s5_async_level", lvl, 5'b0);
    chk("s5_async_strobe", stb, 5'b0);
    chk("s5_async_evt", evt, 5'b0);
    wait_cyc(3);
    RST_N = 1'b1;
    e2 = cyc + 1;
    push(e2 + 10, 5'b01000); push(e2 + 50, 5'b01000);
    wait_until(e2 + 9);  chk("s5_re_level0", lvl, 5'b0);
    wait_until(e2 + 10); chk("s5_re_level1", lvl, 5'b01000);
    wait_until(e2 + 55);
    btn_raw = 5'b0;
    wait_cyc(30);
    chk("s5_rel_level", lvl, 5'b0);

    wait_cyc(5);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL strobe_never cyc=%0d got=none want=%b", e.cyc, e.m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
